// File: rtl/readout_frame_packer_if.sv
// Bundle of the packer's data-side signals.
//   In_TransmitOnb      : ASIC transmit-on, low active, asynchronous
//   In_Parallel_Data    : deserialized 16-bit word
//   In_Parallel_Data_En : one-cycle strobe qualifying In_Parallel_Data
//   In_Frame_Ready      : consumer accepts the FIFO head word
//   Out_Frame_Data      : FIFO head word (0 when empty)
//   Out_Frame_Valid     : FIFO non-empty
//   Out_Busy            : packer FSM not idle
//   Out_Overflow        : a data word was dropped in the current/last frame
//   Out_Word_Count      : data words accepted in the current/last frame
// Modport master is the packer side, slave is the deserializer/consumer side.
interface readout_frame_packer_if;
  logic        In_TransmitOnb;
  logic [15:0] In_Parallel_Data;
  logic        In_Parallel_Data_En;
  logic        In_Frame_Ready;
  logic [15:0] Out_Frame_Data;
  logic        Out_Frame_Valid;
  logic        Out_Busy;
  logic        Out_Overflow;
  logic [15:0] Out_Word_Count;

  modport master (
    input  In_TransmitOnb, In_Parallel_Data, In_Parallel_Data_En, In_Frame_Ready,
    output Out_Frame_Data, Out_Frame_Valid, Out_Busy, Out_Overflow, Out_Word_Count
  );

  modport slave (
    output In_TransmitOnb, In_Parallel_Data, In_Parallel_Data_En, In_Frame_Ready,
    input  Out_Frame_Data, Out_Frame_Valid, Out_Busy, Out_Overflow, Out_Word_Count
  );
endinterface

// File: rtl/readout_frame_packer.sv
// Wraps the words received during one ASIC transmit window into a frame
//   HEADER_WORD, {CHIP_ID, frame_no}, data..., count, xor checksum, TRAILER_WORD
// and buffers it in a first-word-fall-through FIFO toward the event builder.
// Ports:
//   Clk : system clock
//   Rst : synchronous active-high reset
//   bus : readout_frame_packer_if.master (input words, FIFO output, status)
module readout_frame_packer #(
  parameter logic [7:0]  CHIP_ID      = 8'h00,
  parameter int          FIFO_DEPTH   = 16,
  parameter int          TAIL_WAIT    = 8,
  parameter logic [15:0] HEADER_WORD  = 16'hFA5A,
  parameter logic [15:0] TRAILER_WORD = 16'hFEEE
) (
  input  logic                  Clk,
  input  logic                  Rst,
  readout_frame_packer_if.master bus
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, HDR0, HDR1, DATA, TAIL, TRL_CNT, TRL_SUM, TRL_END
  } state_t;

  state_t state_q, state_d;

  // transmit-on synchronizer; idles high so reset looks like "not transmitting"
  logic tonb_m_q, tonb_s_q;

  // FIFO
  logic [15:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   fill_q, fill_d;
  logic full, empty, push, push_ok, pop;
  logic [15:0] push_data;

  // frame datapath
  logic [15:0] hold_q, hold_d;
  logic        hold_full_q, hold_full_d, hold_drain;
  logic [15:0] count_q, count_d, sum_q, sum_d, tail_q, tail_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  frame_q, frame_d;

  assign full    = (fill_q == (AW+1)'(FIFO_DEPTH));
  assign empty   = (fill_q == '0);
  assign pop     = !empty && bus.In_Frame_Ready;
  // full is judged before the pop, so a full FIFO refuses a same-cycle push
  assign push_ok = push && !full;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      tonb_m_q <= 1'b1;
      tonb_s_q <= 1'b1;
    end else begin
      tonb_m_q <= bus.In_TransmitOnb;
      tonb_s_q <= tonb_m_q;
    end
  end

  // ---- FSM: state register
  always_ff @(posedge Clk) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---- FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!tonb_s_q) state_d = HDR0;
      HDR0:    if (!full) state_d = HDR1;
      HDR1:    if (!full) state_d = DATA;
      DATA:    if (tonb_s_q) state_d = TAIL;
      TAIL:    if (tail_q == '0 && !hold_full_q) state_d = TRL_CNT;
      TRL_CNT: if (!full) state_d = TRL_SUM;
      TRL_SUM: if (!full) state_d = TRL_END;
      TRL_END: if (!full) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- FSM: outputs (FIFO write request)
  always_comb begin
    push       = 1'b0;
    push_data  = '0;
    hold_drain = 1'b0;
    unique case (state_q)
      HDR0:    begin push = 1'b1; push_data = HEADER_WORD; end
      HDR1:    begin push = 1'b1; push_data = {CHIP_ID, frame_q}; end
      DATA, TAIL: begin
        push       = hold_full_q;
        push_data  = hold_q;
        hold_drain = hold_full_q && !full;
      end
      TRL_CNT: begin push = 1'b1; push_data = count_q; end
      TRL_SUM: begin push = 1'b1; push_data = sum_q; end
      TRL_END: begin push = 1'b1; push_data = TRAILER_WORD; end
      default: ;
    endcase
  end

  // ---- frame datapath next state
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    count_d     = count_q;
    sum_d       = sum_q;
    ovf_d       = ovf_q;
    tail_d      = tail_q;
    frame_d     = frame_q;

    if (hold_drain) begin
      hold_full_d = 1'b0;
      count_d     = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
      sum_d       = sum_q ^ hold_q;
    end

    // a draining hold register frees its slot for a same-cycle strobe
    if (bus.In_Parallel_Data_En && (state_q == DATA || state_q == TAIL)) begin
      if (!hold_full_q || hold_drain) begin
        hold_d      = bus.In_Parallel_Data;
        hold_full_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end

    if (state_q == DATA && state_d == TAIL)   tail_d = 16'(TAIL_WAIT);
    else if (state_q == TAIL && tail_q != '0) tail_d = tail_q - 16'd1;

    if (state_q == TRL_END && !full) frame_d = frame_q + 8'd1;

    // status of the previous frame stays visible until the next one starts
    if (state_q == IDLE && state_d == HDR0) begin
      hold_full_d = 1'b0;
      count_d     = '0;
      sum_d       = '0;
      ovf_d       = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      count_q     <= '0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
      tail_q      <= '0;
      frame_q     <= '0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      count_q     <= count_d;
      sum_q       <= sum_d;
      ovf_q       <= ovf_d;
      tail_q      <= tail_d;
      frame_q     <= frame_d;
    end
  end

  // ---- FIFO
  always_comb begin
    unique case ({push_ok, pop})
      2'b10:   fill_d = fill_q + (AW+1)'(1);
      2'b01:   fill_d = fill_q - (AW+1)'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      fill_q <= fill_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // storage is not reset; the read port is masked while empty
  always_ff @(posedge Clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

  assign bus.Out_Frame_Data  = empty ? 16'h0000 : mem[rd_ptr_q];
  assign bus.Out_Frame_Valid = !empty;
  assign bus.Out_Busy        = (state_q != IDLE);
  assign bus.Out_Overflow    = ovf_q;
  assign bus.Out_Word_Count  = count_q;

endmodule

// File: tb/tb_readout_frame_packer.sv
module tb_readout_frame_packer;
  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  readout_frame_packer_if bus();

  readout_frame_packer #(
    .CHIP_ID(8'h05), .FIFO_DEPTH(8), .TAIL_WAIT(8),
    .HEADER_WORD(16'hFA5A), .TRAILER_WORD(16'hFEEE)
  ) dut (
    .Clk(Clk), .Rst(Rst), .bus(bus.master)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] expq[$];
  logic [15:0] mon_exp;
  logic [7:0]  fno = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every accepted head word is compared with the queue head
  always @(negedge Clk) begin
    if (!Rst && bus.Out_Frame_Valid && bus.In_Frame_Ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word got %h want none", bus.Out_Frame_Data);
      end else begin
        mon_exp = expq.pop_front();
        chk("frame_word", {16'h0, bus.Out_Frame_Data}, {16'h0, mon_exp});
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_busy(input logic val);
    int n = 0;
    while (bus.Out_Busy !== val && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL busy_wait got timeout want busy=%0b", val);
    end
  endtask

  task automatic send(input logic [15:0] w);
    bus.In_Parallel_Data    = w;
    bus.In_Parallel_Data_En = 1'b1;
    tick();
    bus.In_Parallel_Data_En = 1'b0;
  endtask

  // push the full expected frame for the given accepted data words
  task automatic expect_frame(input logic [15:0] w[$]);
    logic [15:0] x = 16'h0;
    expq.push_back(16'hFA5A);
    expq.push_back({8'h05, fno});
    foreach (w[i]) begin
      expq.push_back(w[i]);
      x ^= w[i];
    end
    expq.push_back(16'(w.size()));
    expq.push_back(x);
    expq.push_back(16'hFEEE);
    fno++;
  endtask

  task automatic start_frame();
    bus.In_TransmitOnb = 1'b0;
    wait_busy(1'b1);
    ticks(3);
  endtask

  task automatic end_frame();
    bus.In_TransmitOnb = 1'b1;
    wait_busy(1'b0);
  endtask

  initial begin
    logic [15:0] q[$];
    int n;
    Rst = 1'b1;
    bus.In_TransmitOnb      = 1'b1;
    bus.In_Parallel_Data    = 16'h0;
    bus.In_Parallel_Data_En = 1'b0;
    bus.In_Frame_Ready      = 1'b0;
    ticks(3);
    Rst = 1'b0;
    tick();
    chk("rst_data",  {16'h0, bus.Out_Frame_Data}, 32'h0);
    chk("rst_valid", {31'h0, bus.Out_Frame_Valid}, 32'h0);
    chk("rst_busy",  {31'h0, bus.Out_Busy}, 32'h0);
    chk("rst_ovf",   {31'h0, bus.Out_Overflow}, 32'h0);
    chk("rst_count", {16'h0, bus.Out_Word_Count}, 32'h0);

    // frame 0: hand-computed reference sequence, consumer always ready
    bus.In_Frame_Ready = 1'b1;
    expq.push_back(16'hFA5A); expq.push_back(16'h0500);
    expq.push_back(16'h1234); expq.push_back(16'hABCD); expq.push_back(16'h0F0F);
    expq.push_back(16'h0003); expq.push_back(16'hB6F6); expq.push_back(16'hFEEE);
    fno = 8'h01;
    start_frame();
    send(16'h1234);
    tick();
    send(16'hABCD);
    send(16'h0F0F);
    end_frame();
    ticks(3);
    chk("f0_count", {16'h0, bus.Out_Word_Count}, 32'd3);
    chk("f0_ovf",   {31'h0, bus.Out_Overflow}, 32'h0);

    // frame 1: consumer stalled for the whole frame; 8 words fit exactly
    bus.In_Frame_Ready = 1'b0;
    q = {16'h1234, 16'hABCD, 16'h0F0F};
    expect_frame(q);
    start_frame();
    send(16'h1234); send(16'hABCD); send(16'h0F0F);
    end_frame();
    ticks(2);
    chk("f1_valid_held", {31'h0, bus.Out_Frame_Valid}, 32'h1);
    chk("f1_ovf",        {31'h0, bus.Out_Overflow}, 32'h0);
    bus.In_Frame_Ready = 1'b1;
    ticks(12);
    chk("f1_drained", {31'h0, bus.Out_Frame_Valid}, 32'h0);

    // frame 2: overflow; 6 words fill the FIFO, 7th held, 8th dropped
    bus.In_Frame_Ready = 1'b0;
    q = {16'h1001, 16'h2002, 16'h3003, 16'h4004, 16'h5005, 16'h6006, 16'h7007};
    expect_frame(q);
    start_frame();
    for (int i = 1; i <= 8; i++) send(16'(i * 16'h1001));
    bus.In_TransmitOnb = 1'b1;
    ticks(20);
    chk("f2_ovf",     {31'h0, bus.Out_Overflow}, 32'h1);
    chk("f2_count6",  {16'h0, bus.Out_Word_Count}, 32'd6);
    chk("f2_stalled", {31'h0, bus.Out_Busy}, 32'h1);
    bus.In_Frame_Ready = 1'b1;
    wait_busy(1'b0);
    ticks(15);
    chk("f2_count7", {16'h0, bus.Out_Word_Count}, 32'd7);
    chk("f2_ovf_hold", {31'h0, bus.Out_Overflow}, 32'h1);

    // frame 3: tail window; word 5 cycles after rise kept, 20 cycles after ignored
    q = {16'h1111, 16'h2222};
    expect_frame(q);
    start_frame();
    send(16'h1111);
    bus.In_TransmitOnb = 1'b1;
    ticks(5);
    send(16'h2222);
    ticks(14);
    send(16'h3333);
    wait_busy(1'b0);
    ticks(10);
    chk("f3_count", {16'h0, bus.Out_Word_Count}, 32'd2);
    chk("f3_ovf",   {31'h0, bus.Out_Overflow}, 32'h0);

    // reset mid-frame: partial frame lost, frame_no restarts at 0
    bus.In_Frame_Ready = 1'b0;
    start_frame();
    send(16'h4444);
    send(16'h5555);
    ticks(2);
    chk("pre_rst_valid", {31'h0, bus.Out_Frame_Valid}, 32'h1);
    Rst = 1'b1;
    tick();
    chk("rst_flush_valid", {31'h0, bus.Out_Frame_Valid}, 32'h0);
    chk("rst_flush_busy",  {31'h0, bus.Out_Busy}, 32'h0);
    expq.delete();
    fno = 8'h00;
    q = {16'h6666};
    expect_frame(q);
    Rst = 1'b0;
    bus.In_Frame_Ready = 1'b1;
    wait_busy(1'b1);
    ticks(3);
    send(16'h6666);
    end_frame();
    ticks(3);
    chk("post_rst_count", {16'h0, bus.Out_Word_Count}, 32'd1);

    // 257 empty frames: frame number wraps through FF back to 00
    for (int f = 0; f < 257; f++) begin
      q.delete();
      expect_frame(q);
      bus.In_TransmitOnb = 1'b0;
      wait_busy(1'b1);
      bus.In_TransmitOnb = 1'b1;
      wait_busy(1'b0);
    end

    n = 0;
    while (expq.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("queue_drained", expq.size(), 32'd0);
    chk("final_valid", {31'h0, bus.Out_Frame_Valid}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
